ula_arbiter: RTL and testbench

Two-requester arbiter that shares the single `ula` instance between the main pipeline (port 0) and an auxiliary multi-cycle unit (port 1). It accepts one operation at a time through a valid/ready request handshake and drives the ALU from registered operands. It captures `result`/`Zero_Flag` into a response register and holds it until the owning requester acknowledges it. The block sits between the requesters and the external `ula` instance; it does not compute anything itself.

---
 rtl/ula_arbiter.sv | 149 ++++++++++++++
 tb/tb_ula_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_arbiter.sv
// Two-port arbiter sharing one external ula: one operation in flight, registered
// ALU operands, and a held response returned to the port that issued it.
package ula_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned CNT_W  = 4;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] in2;
    logic [DATA_W-1:0] in1;
  } alu_req_t;

endpackage

module ula_arbiter
  import ula_arbiter_pkg::*;
#(
  parameter bit          P0_PRIORITY = 1'b0,
  parameter int unsigned MAX_WAIT    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  input  logic              p1_valid,
  output logic              p0_ready,
  output logic              p1_ready,
  input  logic [DATA_W-1:0] p0_in1,
  input  logic [DATA_W-1:0] p1_in1,
  input  logic [DATA_W-1:0] p0_in2,
  input  logic [DATA_W-1:0] p1_in2,
  input  logic [OP_W-1:0]   p0_op,
  input  logic [OP_W-1:0]   p1_op,
  output logic              p0_resp_valid,
  output logic              p1_resp_valid,
  input  logic              p0_resp_ready,
  input  logic              p1_resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e            state_q, state_d;
  alu_req_t          req_q, req_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              zero_q, zero_d;
  logic              grant1_c;

  // Winner among the currently valid ports; only meaningful in IDLE.
  always_comb begin
    grant1_c = 1'b0;
    if (p1_valid && !p0_valid) begin
      grant1_c = 1'b1;
    end else if (p1_valid && p0_valid) begin
      grant1_c = P0_PRIORITY ? (wait_q == WAIT_MAX) : !last_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    owner_d  = owner_q;
    last_d   = last_q;
    wait_d   = wait_q;
    res_d    = res_q;
    zero_d   = zero_q;
    p0_ready = 1'b0;
    p1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        p0_ready = p0_valid && !grant1_c;
        p1_ready = p1_valid && grant1_c;
        if (!p1_valid) begin
          wait_d = '0;
        end
        if (p1_ready) begin
          req_d   = '{op: p1_op, in2: p1_in2, in1: p1_in1};
          owner_d = 1'b1;
          last_d  = 1'b1;
          wait_d  = '0;
          state_d = ISSUE;
        end else if (p0_ready) begin
          req_d   = '{op: p0_op, in2: p0_in2, in1: p0_in1};
          owner_d = 1'b0;
          last_d  = 1'b0;
          // Count port-0 wins that left port 1 waiting, saturating at the limit.
          if (p1_valid && (wait_q != WAIT_MAX)) begin
            wait_d = wait_q + CNT_W'(1);
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        res_d   = alu_result;
        zero_d  = alu_zero;
        state_d = RESP;
      end
      RESP: begin
        if (owner_q ? p1_resp_ready : p0_resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      wait_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wait_q  <= wait_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  assign p0_resp_valid = (state_q == RESP) && !owner_q;
  assign p1_resp_valid = (state_q == RESP) && owner_q;
  assign resp_result   = res_q;
  assign resp_zero     = zero_q;
  assign alu_in1       = req_q.in1;
  assign alu_in2       = req_q.in2;
  assign alu_op        = req_q.op;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_ula_arbiter.sv
// Bench for ula_arbiter: a round-robin and a priority (MAX_WAIT=2) instance share
// stimulus; each is checked against a transaction-level model every cycle.
module tb_ula_arbiter;

  localparam logic [3:0] OP_AND = 4'h0, OP_OR  = 4'h1, OP_ADD = 4'h2, OP_XOR = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h6, OP_SLT = 4'h7, OP_SLL = 4'h8, OP_SRL = 4'h9;
  localparam logic [3:0] OP_SRA = 4'hA, OP_NOR = 4'hC, OP_BAD = 4'hF;
  localparam int MAXW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic p0_valid, p1_valid, p0_resp_ready, p1_resp_ready;
  logic [31:0] p0_in1, p0_in2, p1_in1, p1_in2;
  logic [3:0]  p0_op, p1_op;

  logic [1:0]  p0_ready_w, p1_ready_w, p0_rv_w, p1_rv_w, zero_w, busy_w, alu_zero_w;
  logic [31:0] res_w [2];
  logic [31:0] alu_in1_w [2];
  logic [31:0] alu_in2_w [2];
  logic [31:0] alu_res_w [2];
  logic [3:0]  alu_op_w [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the external ula.
  function automatic logic [31:0] alu_f(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_XOR:  return a ^ b;
      OP_SUB:  return a - b;
      OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
      OP_SLL:  return b << a[4:0];
      OP_SRL:  return b >> a[4:0];
      OP_SRA:  return 32'($signed(b) >>> a[4:0]);
      OP_NOR:  return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ula_arbiter #(.P0_PRIORITY(g == 1), .MAX_WAIT(MAXW)) u_dut (
      .clk(clk), .rst(rst),
      .p0_valid(p0_valid), .p1_valid(p1_valid),
      .p0_ready(p0_ready_w[g]), .p1_ready(p1_ready_w[g]),
      .p0_in1(p0_in1), .p1_in1(p1_in1), .p0_in2(p0_in2), .p1_in2(p1_in2),
      .p0_op(p0_op), .p1_op(p1_op),
      .p0_resp_valid(p0_rv_w[g]), .p1_resp_valid(p1_rv_w[g]),
      .p0_resp_ready(p0_resp_ready), .p1_resp_ready(p1_resp_ready),
      .resp_result(res_w[g]), .resp_zero(zero_w[g]),
      .alu_in1(alu_in1_w[g]), .alu_in2(alu_in2_w[g]), .alu_op(alu_op_w[g]),
      .alu_result(alu_res_w[g]), .alu_zero(alu_zero_w[g]),
      .busy(busy_w[g])
    );
    assign alu_res_w[g]  = alu_f(alu_op_w[g], alu_in1_w[g], alu_in2_w[g]);
    assign alu_zero_w[g] = (alu_res_w[g] == 32'd0);
  end

  // Model: age counts cycles since acceptance (0 = nothing in flight, 2 = response held).
  int          m_age [2];
  bit          m_owner [2];
  bit          m_last [2];
  int          m_starve [2];
  logic [31:0] m_in1 [2];
  logic [31:0] m_in2 [2];
  logic [3:0]  m_op [2];
  logic [31:0] m_res [2];
  bit          m_zero [2];
  bit          acc_v [2];
  bit          acc_p [2];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_age[m] = 0; m_last[m] = 1'b1; m_starve[m] = 0; acc_v[m] = 1'b0;
    end
  endtask

  function automatic bit winner(int m);
    if (p0_valid && !p1_valid) return 1'b0;
    if (p1_valid && !p0_valid) return 1'b1;
    if (m == 0) return (m_last[m] == 1'b0);
    return (m_starve[m] >= MAXW);
  endfunction

  task automatic check_model(int m);
    bit w;
    bit idle;
    w = winner(m);
    idle = (m_age[m] == 0);
    chk1($sformatf("d%0d p0_ready", m), p0_ready_w[m], idle && p0_valid && !w);
    chk1($sformatf("d%0d p1_ready", m), p1_ready_w[m], idle && p1_valid && w);
    chk1($sformatf("d%0d busy", m), busy_w[m], !idle);
    chk1($sformatf("d%0d p0_resp_valid", m), p0_rv_w[m], m_age[m] == 2 && !m_owner[m]);
    chk1($sformatf("d%0d p1_resp_valid", m), p1_rv_w[m], m_age[m] == 2 && m_owner[m]);
    if (m_age[m] == 2) begin
      chk($sformatf("d%0d resp_result", m), res_w[m], m_res[m]);
      chk1($sformatf("d%0d resp_zero", m), zero_w[m], m_zero[m]);
    end
    if (!idle) begin
      chk($sformatf("d%0d alu_in1", m), alu_in1_w[m], m_in1[m]);
      chk($sformatf("d%0d alu_in2", m), alu_in2_w[m], m_in2[m]);
      chk($sformatf("d%0d alu_op", m), 32'(alu_op_w[m]), 32'(m_op[m]));
    end
  endtask

  task automatic model_step(int m);
    bit w;
    w = winner(m);
    acc_v[m] = 1'b0;
    if (m_age[m] == 0) begin
      if (p0_valid || p1_valid) begin
        acc_v[m] = 1'b1; acc_p[m] = w;
        m_age[m] = 1; m_owner[m] = w; m_last[m] = w;
        m_in1[m] = w ? p1_in1 : p0_in1;
        m_in2[m] = w ? p1_in2 : p0_in2;
        m_op[m]  = w ? p1_op : p0_op;
        m_res[m] = alu_f(m_op[m], m_in1[m], m_in2[m]);
        m_zero[m] = (m_res[m] == 32'd0);
        if (w) m_starve[m] = 0;
        else if (p1_valid) m_starve[m] = (m_starve[m] + 1 > MAXW) ? MAXW : m_starve[m] + 1;
        else m_starve[m] = 0;
      end else begin
        m_starve[m] = 0;
      end
    end else if (m_age[m] == 1) begin
      m_age[m] = 2;
    end else if (m_owner[m] ? p1_resp_ready : p0_resp_ready) begin
      m_age[m] = 0;
    end
  endtask

  // One clock: check both instances, advance the model, land 1 time unit past the edge.
  task automatic cycle();
    #1;
    for (int m = 0; m < 2; m++) check_model(m);
    for (int m = 0; m < 2; m++) model_step(m);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(string tag);
    for (int m = 0; m < 2; m++) begin
      chk1($sformatf("%s d%0d p0_ready", tag, m), p0_ready_w[m], 1'b0);
      chk1($sformatf("%s d%0d p1_ready", tag, m), p1_ready_w[m], 1'b0);
      chk1($sformatf("%s d%0d p0_resp_valid", tag, m), p0_rv_w[m], 1'b0);
      chk1($sformatf("%s d%0d p1_resp_valid", tag, m), p1_rv_w[m], 1'b0);
      chk1($sformatf("%s d%0d busy", tag, m), busy_w[m], 1'b0);
      chk1($sformatf("%s d%0d resp_zero", tag, m), zero_w[m], 1'b0);
      chk($sformatf("%s d%0d resp_result", tag, m), res_w[m], 32'd0);
      chk($sformatf("%s d%0d alu_in1", tag, m), alu_in1_w[m], 32'd0);
      chk($sformatf("%s d%0d alu_in2", tag, m), alu_in2_w[m], 32'd0);
      chk($sformatf("%s d%0d alu_op", tag, m), 32'(alu_op_w[m]), 32'd0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    p0_valid = 1'b0; p1_valid = 1'b0;
    p0_resp_ready = 1'b1; p1_resp_ready = 1'b1;
    for (int i = 0; i < 10 && (m_age[0] != 0 || m_age[1] != 0); i++) cycle();
    #1;
    chk("drain busy", 32'(busy_w), 32'd0);
  endtask

  function automatic logic [3:0] pick_op();
    case ($urandom_range(0, 10))
      0: return OP_AND;  1: return OP_OR;   2: return OP_ADD;  3: return OP_XOR;
      4: return OP_SUB;  5: return OP_SLT;  6: return OP_SLL;  7: return OP_SRL;
      8: return OP_SRA;  9: return OP_NOR;  default: return OP_BAD;
    endcase
  endfunction

  function automatic logic [31:0] pick_val();
    if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 3));
    return 32'($urandom());
  endfunction

  typedef struct {
    bit          port;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          zero;
  } vec_t;

  vec_t vecs [9];
  int   ord [2][6];
  int   n_ord [2];
  int   exp_ord [2][6];

  initial begin
    vecs[0] = '{1'b0, OP_ADD, 32'd5,          32'd7,          32'd12,         1'b0};
    vecs[1] = '{1'b1, OP_SUB, 32'd3,          32'd3,          32'd0,          1'b1};
    vecs[2] = '{1'b0, OP_SRA, 32'd4,          32'h8000_0000,  32'hF800_0000,  1'b0};
    vecs[3] = '{1'b0, OP_BAD, 32'd9,          32'd9,          32'd0,          1'b1};
    vecs[4] = '{1'b1, OP_AND, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0};
    vecs[5] = '{1'b1, OP_OR,  32'h0000_000F,  32'h0000_00F0,  32'h0000_00FF,  1'b0};
    vecs[6] = '{1'b0, OP_SLT, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0};
    vecs[7] = '{1'b1, OP_SLL, 32'd31,         32'd1,          32'h8000_0000,  1'b0};
    vecs[8] = '{1'b0, OP_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
    exp_ord[0] = '{0, 1, 0, 1, 0, 1};
    exp_ord[1] = '{0, 0, 1, 0, 0, 1};

    p0_valid = 1'b0; p1_valid = 1'b0; p0_resp_ready = 1'b1; p1_resp_ready = 1'b1;
    p0_in1 = '0; p0_in2 = '0; p1_in1 = '0; p1_in2 = '0; p0_op = '0; p1_op = '0;
    model_reset();

    #1 rst = 1'b1;
    #1 chk_reset("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // Port 0 ADD 5+7 with explicit latency checks.
    p0_valid = 1'b1; p0_op = OP_ADD; p0_in1 = 32'd5; p0_in2 = 32'd7;
    #1 chk1("t1 p0_ready at N", p0_ready_w[0], 1'b1);
    cycle();
    p0_valid = 1'b0;
    chk1("t1 busy at N+1", busy_w[0], 1'b1);
    cycle();
    chk1("t1 p0_resp_valid at N+2", p0_rv_w[0], 1'b1);
    chk("t1 resp_result", res_w[0], 32'd12);
    chk1("t1 resp_zero", zero_w[0], 1'b0);
    chk1("t1 p1_resp_valid", p1_rv_w[0], 1'b0);
    cycle();
    chk1("t1 busy at N+3", busy_w[0], 1'b0);

    // Single-port operation table.
    foreach (vecs[i]) begin
      if (vecs[i].port) begin
        p1_valid = 1'b1; p1_op = vecs[i].op; p1_in1 = vecs[i].a; p1_in2 = vecs[i].b;
      end else begin
        p0_valid = 1'b1; p0_op = vecs[i].op; p0_in1 = vecs[i].a; p0_in2 = vecs[i].b;
      end
      cycle();
      p0_valid = 1'b0; p1_valid = 1'b0;
      cycle();
      for (int m = 0; m < 2; m++) begin
        chk1($sformatf("tbl%0d d%0d resp_valid", i, m),
             vecs[i].port ? p1_rv_w[m] : p0_rv_w[m], 1'b1);
        chk($sformatf("tbl%0d d%0d result", i, m), res_w[m], vecs[i].res);
        chk1($sformatf("tbl%0d d%0d zero", i, m), zero_w[m], vecs[i].zero);
      end
      cycle();
    end

    // Contention: both ports valid continuously, order per mode.
    do_reset();
    n_ord[0] = 0; n_ord[1] = 0;
    for (int m = 0; m < 2; m++) for (int k = 0; k < 6; k++) ord[m][k] = 9;
    p0_valid = 1'b1; p0_op = OP_ADD; p0_in1 = 32'd100; p0_in2 = 32'd1;
    p1_valid = 1'b1; p1_op = OP_SUB; p1_in1 = 32'd50;  p1_in2 = 32'd8;
    for (int c = 0; c < 40 && (n_ord[0] < 6 || n_ord[1] < 6); c++) begin
      cycle();
      for (int m = 0; m < 2; m++)
        if (acc_v[m] && n_ord[m] < 6) begin
          ord[m][n_ord[m]] = int'(acc_p[m]);
          n_ord[m]++;
        end
    end
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < 6; k++)
        chk($sformatf("order d%0d op%0d", m, k), 32'(ord[m][k]), 32'(exp_ord[m][k]));
    drain();

    // Port 1 SUB 3-3 held while its resp_ready is low.
    p1_resp_ready = 1'b0;
    p1_valid = 1'b1; p1_op = OP_SUB; p1_in1 = 32'd3; p1_in2 = 32'd3;
    cycle();
    p1_valid = 1'b0;
    cycle();
    p0_valid = 1'b1; p0_op = OP_XOR; p0_in1 = 32'h55; p0_in2 = 32'hAA;
    for (int k = 0; k < 5; k++) begin
      #1;
      for (int m = 0; m < 2; m++) begin
        chk1($sformatf("hold%0d d%0d p1_resp_valid", k, m), p1_rv_w[m], 1'b1);
        chk($sformatf("hold%0d d%0d result", k, m), res_w[m], 32'd0);
        chk1($sformatf("hold%0d d%0d zero", k, m), zero_w[m], 1'b1);
        chk1($sformatf("hold%0d d%0d p0_ready", k, m), p0_ready_w[m], 1'b0);
        chk1($sformatf("hold%0d d%0d busy", k, m), busy_w[m], 1'b1);
      end
      cycle();
    end
    p1_resp_ready = 1'b1;
    cycle();
    #1;
    chk1("hold release busy", busy_w[0], 1'b0);
    chk1("hold release p0_ready", p0_ready_w[0], 1'b1);
    drain();

    // Reset pulse while an operation is in ISSUE.
    p0_valid = 1'b1; p0_op = OP_ADD; p0_in1 = 32'd20; p0_in2 = 32'd22;
    cycle();
    p0_valid = 1'b0;
    chk1("rst busy before pulse", busy_w[0], 1'b1);
    #2 rst = 1'b1;
    #1 chk_reset("rst issue");
    @(posedge clk);
    #1 chk_reset("rst held");
    rst = 1'b0;
    model_reset();
    p1_valid = 1'b1; p1_op = OP_OR; p1_in1 = 32'h3; p1_in2 = 32'h4;
    cycle();
    p1_valid = 1'b0;
    chk1("post-rst busy", busy_w[0], 1'b1);
    cycle();
    chk1("post-rst p1_resp_valid", p1_rv_w[0], 1'b1);
    chk("post-rst result", res_w[0], 32'd7);
    cycle();

    // Randomised traffic against the model.
    for (int c = 0; c < 600; c++) begin
      p0_valid = ($urandom_range(0, 99) < 60);
      p1_valid = ($urandom_range(0, 99) < 60);
      p0_op = pick_op(); p0_in1 = pick_val(); p0_in2 = pick_val();
      p1_op = pick_op(); p1_in1 = pick_val(); p1_in2 = pick_val();
      p0_resp_ready = ($urandom_range(0, 99) < 75);
      p1_resp_ready = ($urandom_range(0, 99) < 75);
      cycle();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
